// File: rtl/program_loader.sv
// Byte-serial loader: count, MSB-first 32-bit words and XOR checksum in; one RAM write per word,
// one cycle after its 4th byte. in_ready drops in IDLE/WRITE/RUN/ERROR, so bytes stall there.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_save,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  run,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, WRITE, CHECK, RUN, ERROR
    } state_t;

    state_t                state, next;
    logic [7:0]            count;
    logic [7:0]            widx;
    logic [1:0]            byte_cnt;
    logic [7:0]            csum;
    logic [DATA_WIDTH-1:0] word;
    logic                  accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next     = state;
        in_ready = 1'b0;
        mem_save = 1'b0;
        busy     = 1'b0;
        run      = 1'b0;
        error    = 1'b0;
        case (state)
            IDLE: if (start) next = COUNT;
            COUNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) next = (in_data == 8'd0) ? CHECK : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && byte_cnt == 2'd3) next = WRITE;
            end
            WRITE: begin
                mem_save = 1'b1;
                busy     = 1'b1;
                next     = (widx + 8'd1 == count) ? CHECK : DATA;
            end
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) next = (in_data == csum) ? RUN : ERROR;
            end
            RUN: begin
                run = 1'b1;
                if (start) next = COUNT;
            end
            ERROR: begin
                error = 1'b1;
                if (start) next = COUNT;
            end
            default: next = IDLE;
        endcase
    end

    // mem_addr/mem_data are loaded on the 4th byte so they are already valid during WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            widx     <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            word     <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                COUNT: if (accept) begin
                    count    <= in_data;
                    widx     <= '0;
                    byte_cnt <= '0;
                    csum     <= '0;
                end
                DATA: if (accept) begin
                    word     <= {word[DATA_WIDTH-9:0], in_data};
                    csum     <= csum ^ in_data;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_addr <= ADDR_WIDTH'(widx);
                        mem_data <= {word[DATA_WIDTH-9:0], in_data};
                    end
                end
                WRITE: widx <= widx + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-serial program loader that fills the computer's instruction/data RAM and then releases the CPU clock. It receives a framed byte stream (word count, 32-bit words MSB-first, XOR checksum) over a valid/ready handshake. It issues one RAM write per assembled word and asserts `run` only after the frame verifies. It is the hardware writer side of RAM initialisation: it replaces backdoor loading of `ram.mem[]`, and its `run` output drives the `Clock` enable.

## Interface
- `ADDR_WIDTH`, default 8: RAM word-address width; must be ≥ 8.
- `DATA_WIDTH`, default 32: RAM word width; fixed at 32 (4 bytes per word).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a new frame.
- `in_valid`  in  1: `in_data` holds a byte.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_save`  out  1: RAM write strobe.
- `mem_addr`  out  ADDR_WIDTH: RAM word address.
- `mem_data`  out  32: RAM write data.
- `busy`  out  1: a frame is in progress.
- `run`  out  1: CPU clock enable.
- `error`  out  1: the last frame failed its checksum.

## Operation
- Frame format: count byte N (0..255), then N×4 data bytes, then a checksum byte.
  - Each word is sent MSB first: first byte → [31:24], fourth byte → [7:0].
  - Checksum is the XOR of all data bytes, initial value 0x00. The count byte is not included.
- A byte transfers on a rising edge where `in_valid && in_ready`. `in_valid` may drop at any time; a byte without `in_ready` is not consumed.
- States and transitions:
  - IDLE: `in_ready`=0. `start` → COUNT.
  - COUNT: `in_ready`=1. On accept, latch N, clear the word index and checksum. N=0 → CHECK; otherwise → DATA.
  - DATA: `in_ready`=1. On accept, shift the byte into the word register and XOR it into the checksum. After the 4th byte of a word → WRITE.
  - WRITE: `in_ready`=0. `mem_save`=1 for exactly this cycle, with `mem_addr`=word index and `mem_data`=assembled word. Then increment the index. If index+1 == N → CHECK; otherwise → DATA.
  - CHECK: `in_ready`=1. On accept, byte == checksum → RUN; otherwise → ERROR.
  - RUN: `run`=1. `start` → COUNT and `run` drops.
  - ERROR: `error`=1. `start` → COUNT and `error` clears.
- `start` is ignored in COUNT, DATA, WRITE and CHECK.
- `busy`=1 in COUNT, DATA, WRITE and CHECK.
- Words are written to addresses 0..N−1 in order. Addresses ≥ N are never touched.
- RAM writes completed before a checksum failure are not undone. `run` stays 0 in that case.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_save`, `busy`, `run`, `error` = 0; `mem_addr`, `mem_data`, word index and checksum = 0.
- Reset takes effect immediately, in any state, without waiting for a clock edge. A partial word is discarded and no further `mem_save` is issued.
- `start` sampled at edge t: `in_ready`=1 from t+1.
- 4th byte of a word accepted at edge t: `mem_save`=1 during cycle t+1 (one-cycle write latency), and `in_ready`=1 again from t+2.
- With back-to-back `in_valid`, a word costs 5 cycles and a full frame costs 1 + 5N + 1 cycles from the first accept.
- Checksum accepted at edge t: `run` or `error` = 1 from t+1, and `busy`=0 from t+1.
- `mem_addr` and `mem_data` hold their last values outside WRITE. Only `mem_save` qualifies them.

## Test plan
- Nominal load: start, then stream 04, 40 0F 00 01, 40 0F 00 02, 00 01 02 03, 80 00 03 0F, 8F with continuous valid.
  - Required: four `mem_save` pulses with addr 0..3 and data 0x400F0001, 0x400F0002, 0x00010203, 0x8000030F, spaced 5 cycles apart.
  - Required: `run`=1 the cycle after the 8F byte is accepted, `error`=0.
- Bad checksum: same frame, but the last byte is 8E.
  - Required: all four writes occur, then `error`=1, `run`=0, `busy`=0.
  - Then a start plus a valid frame → `error` clears and `run`=1.
- Stalls: nominal frame with `in_valid` toggling pseudo-randomly, plus one byte held during a WRITE cycle.
  - Required: identical writes and data, no byte lost or duplicated, `in_ready`=0 in every WRITE cycle.
- Empty frame: start, then 00, 00.
  - Required: no `mem_save`, `run`=1.
  - Start, then 00, 01 → `error`=1.
- Reset mid-word: assert `reset` after two bytes of word 1.
  - Required: all outputs 0 immediately, no further `mem_save`.
  - Then a start plus nominal frame → correct 4 writes and `run`=1.
- Restart from RUN: a `start` pulse while `run`=1 → `run`=0 next cycle, `busy`=1.
  - A `start` pulse during DATA → ignored, and the frame completes normally.
